// File: rtl/m_axi_wr_burst_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | m_axi_wr_burst_arbiter_if: requester FIFOs <-> arbiter <-> shared AXI4 write port |
// | Rev 1.0 - optional b_resp/done_err under M_AXI_WR_ARB_BRESP_EN                    |
// +-----------------------------------------------------------------------------------+
interface m_axi_wr_burst_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int LEN_WIDTH  = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
    logic [NUM_REQ-1:0]            wdata_valid;
    logic [NUM_REQ-1:0]            wdata_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
    logic                          aw_valid;
    logic                          aw_ready;
    logic [ADDR_WIDTH-1:0]         aw_addr;
    logic [LEN_WIDTH-1:0]          aw_len;
    logic                          w_valid;
    logic                          w_ready;
    logic [DATA_WIDTH-1:0]         w_data;
    logic                          w_last;
    logic                          b_valid;
    logic                          b_ready;
    logic [NUM_REQ-1:0]            done;
`ifdef M_AXI_WR_ARB_BRESP_EN
    logic [1:0]                    b_resp;
    logic [NUM_REQ-1:0]            done_err;
`endif

    modport master (
        input  req_valid, req_addr, req_len, wdata_valid, wdata, aw_ready, w_ready, b_valid,
        output req_ready, wdata_ready, aw_valid, aw_addr, aw_len, w_valid, w_data, w_last,
        output b_ready, done
`ifdef M_AXI_WR_ARB_BRESP_EN
        , input b_resp, output done_err
`endif
    );

    modport slave (
        output req_valid, req_addr, req_len, wdata_valid, wdata, aw_ready, w_ready, b_valid,
        input  req_ready, wdata_ready, aw_valid, aw_addr, aw_len, w_valid, w_data, w_last,
        input  b_ready, done
`ifdef M_AXI_WR_ARB_BRESP_EN
        , output b_resp, input done_err
`endif
    );
endinterface
`default_nettype wire

// File: rtl/m_axi_wr_burst_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | m_axi_wr_burst_arbiter: round-robin AXI4 write-burst arbiter with in-order B routing |
// | Rev 1.0 - define M_AXI_WR_ARB_BRESP_EN to flag SLVERR/DECERR responses on done_err  |
// +-----------------------------------------------------------------------------------+
module m_axi_wr_burst_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int LEN_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 8
) (
    input logic                      clk,
    input logic                      reset,
    input logic                      clk_en,
    m_axi_wr_burst_arbiter_if.master bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = IDW + 1;
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW  = PW + 1;

    localparam logic [CW-1:0]  NREQ_C  = CW'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
    localparam logic [OW-1:0]  MAX_C   = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        gnt_q, gnt_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [OW-1:0]         outstanding_q, outstanding_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [IDW-1:0]        id_fifo_q [MAX_OUTSTANDING];

    logic                  aw_hs, w_hs, b_hs;
    logic                  found;
    logic [IDW-1:0]        pick;
    logic [CW-1:0]         idx;
    logic [IDW-1:0]        head;
    logic [NUM_REQ-1:0]    wdata_ready_w, done_w;

    assign head = id_fifo_q[rd_ptr_q];

    assign bus.aw_valid = (state_q == S_ADDR);
    assign bus.aw_addr  = addr_q;
    assign bus.aw_len   = len_q;
    assign bus.w_valid  = (state_q == S_DATA) && bus.wdata_valid[gnt_q];
    assign bus.w_data   = (state_q == S_DATA) ? bus.wdata[gnt_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.w_last   = (state_q == S_DATA) && (beat_cnt_q == '0);
    assign bus.b_ready  = (outstanding_q != '0);
    assign bus.wdata_ready = wdata_ready_w;
    assign bus.req_ready   = (aw_hs ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q) : '0);
    assign bus.done        = done_w;

    assign aw_hs = bus.aw_valid && bus.aw_ready && clk_en;
    assign w_hs  = bus.w_valid  && bus.w_ready  && clk_en;
    assign b_hs  = bus.b_valid  && bus.b_ready  && clk_en;

`ifdef M_AXI_WR_ARB_BRESP_EN
    // SLVERR (2'b10) and DECERR (2'b11) are the only codes at or above 2'b10
    assign bus.done_err = (bus.b_resp >= 2'b10) ? done_w : '0;
`endif

    // Walk offsets from the far end so the nearest requester after rr_ptr wins last
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr_q} + CW'(i);
            if (idx >= NREQ_C) begin
                idx = idx - NREQ_C;
            end
            if (bus.req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found && (outstanding_q < MAX_C)) begin
                    gnt_d      = pick;
                    addr_d     = bus.req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                    len_d      = bus.req_len[pick*LEN_WIDTH +: LEN_WIDTH];
                    beat_cnt_d = bus.req_len[pick*LEN_WIDTH +: LEN_WIDTH];
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (aw_hs) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    if (beat_cnt_q == '0) begin
                        rr_ptr_d = (gnt_q == LAST_ID) ? '0 : gnt_q + 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q + PW'(aw_hs);
        rd_ptr_d      = rd_ptr_q + PW'(b_hs);
        outstanding_d = outstanding_q;
        if (aw_hs && !b_hs) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!aw_hs && b_hs) begin
            outstanding_d = outstanding_q - 1'b1;
        end
        wdata_ready_w = '0;
        done_w        = '0;
        if (state_q == S_DATA) begin
            wdata_ready_w[gnt_q] = bus.w_ready;
        end
        if (b_hs) begin
            done_w[head] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            gnt_q         <= '0;
            rr_ptr_q      <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            beat_cnt_q    <= '0;
            outstanding_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else if (clk_en) begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            rr_ptr_q      <= rr_ptr_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            beat_cnt_q    <= beat_cnt_d;
            outstanding_q <= outstanding_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Entries are only read while outstanding is non-zero, so storage needs no reset
    always_ff @(posedge clk) begin
        if (!reset && aw_hs) begin
            id_fifo_q[wr_ptr_q] <= gnt_q;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_m_axi_wr_burst_arbiter.sv
`default_nettype none
// Randomised bench for m_axi_wr_burst_arbiter: bench-side requesters and AXI slave,
// checked every cycle against a transaction-level model (burst record + owner queue).
module tb_m_axi_wr_burst_arbiter;
    localparam int NR = 3, AW = 32, DW = 32, LW = 4, MO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b1;
    always #5 clk = ~clk;

    m_axi_wr_burst_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    m_axi_wr_burst_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk    (clk),
        .reset  (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    int n_checks = 0, n_fail = 0, cyc = 0;

    // requesters and slave
    bit              has_req [NR];
    logic [AW-1:0]   r_addr  [NR];
    logic [LW-1:0]   r_len   [NR];
    int              dcnt    [NR];
    logic [NR-1:0]   req_mask;
    int p_req, p_wv, p_awr, p_wr, p_bv, len_max, b_budget, pend_b;
    bit ce_rand;

    // reference model
    bit              cur_v, cur_aw;
    int              cur_own, beats_left, rr;
    logic [AW-1:0]   cur_addr;
    logic [LW-1:0]   cur_len;
    int              idq[$];

    // DUT observations
    int obs_aw, obs_beats, obs_simul;
    int obs_done [NR];
    int grant_log[$];
    int aw_cyc[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input int i, input int n);
        int v;
        v = i * 32'h1000_0000 + n * 32'h0001_9E37 + 32'h55;
        return DW'(v);
    endfunction

    task automatic model_reset();
        cur_v  = 1'b0;
        cur_aw = 1'b0;
        rr     = 0;
        pend_b = 0;
        idq.delete();
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (!has_req[i] && req_mask[i] && ($urandom_range(99) < p_req)) begin
                has_req[i] = 1'b1;
                r_addr[i]  = $urandom & ~32'h3F;
                r_len[i]   = LW'($urandom_range(len_max));
            end
            bus.req_valid[i]        = has_req[i];
            bus.req_addr[i*AW +: AW] = r_addr[i];
            bus.req_len[i*LW +: LW]  = r_len[i];
            bus.wdata_valid[i]      = ($urandom_range(99) < p_wv);
            bus.wdata[i*DW +: DW]   = data_of(i, dcnt[i]);
        end
        bus.aw_ready = ($urandom_range(99) < p_awr);
        bus.w_ready  = ($urandom_range(99) < p_wr);
        bus.b_valid  = (pend_b > 0) && (b_budget != 0) && ($urandom_range(99) < p_bv);
`ifdef M_AXI_WR_ARB_BRESP_EN
        bus.b_resp   = 2'($urandom_range(3));
`endif
        clk_en = ce_rand ? ($urandom_range(9) != 0) : 1'b1;
    endtask

    task automatic evaluate();
        bit exp_awv, exp_wv, aw_hs, w_hs, b_hs, granted;
        logic [NR-1:0] exp_wr, exp_rr, exp_done;
        cyc++;
        if (rst) begin
            model_reset();
            return;
        end
        if (bus.aw_valid && bus.aw_ready && clk_en) begin
            obs_aw++;
            aw_cyc.push_back(cyc);
            for (int k = 0; k < NR; k++) if (bus.req_ready[k]) grant_log.push_back(k);
            if (bus.b_valid && bus.b_ready) obs_simul++;
        end
        if (bus.w_valid && bus.w_ready && clk_en) obs_beats++;
        for (int k = 0; k < NR; k++) if (bus.done[k]) obs_done[k]++;

        exp_awv = cur_v && !cur_aw;
        check_eq("aw_valid", bus.aw_valid, exp_awv);
        if (exp_awv) begin
            check_eq("aw_addr", bus.aw_addr, cur_addr);
            check_eq("aw_len", bus.aw_len, cur_len);
        end
        aw_hs  = exp_awv && bus.aw_ready && clk_en;
        exp_wv = cur_v && cur_aw && bus.wdata_valid[cur_own];
        check_eq("w_valid", bus.w_valid, exp_wv);
        if (exp_wv) begin
            check_eq("w_data", bus.w_data, data_of(cur_own, dcnt[cur_own]));
            check_eq("w_last", bus.w_last, beats_left == 1);
        end
        w_hs = exp_wv && bus.w_ready && clk_en;
        b_hs = bus.b_valid && (idq.size() != 0) && clk_en;
        exp_wr = '0;
        exp_rr = '0;
        exp_done = '0;
        if (cur_v && cur_aw && bus.w_ready) exp_wr[cur_own] = 1'b1;
        if (aw_hs) exp_rr[cur_own] = 1'b1;
        if (b_hs) exp_done[idq[0]] = 1'b1;
        check_eq("wdata_ready", bus.wdata_ready, exp_wr);
        check_eq("req_ready", bus.req_ready, exp_rr);
        check_eq("b_ready", bus.b_ready, idq.size() != 0);
        check_eq("done", bus.done, exp_done);
`ifdef M_AXI_WR_ARB_BRESP_EN
        check_eq("done_err", bus.done_err, bus.b_resp[1] ? exp_done : '0);
`endif
        if (!clk_en) return;

        if (!cur_v) begin
            granted = 1'b0;
            if (idq.size() < MO) begin
                for (int k = 0; k < NR; k++) begin
                    int c;
                    c = (rr + k) % NR;
                    if (!granted && has_req[c]) begin
                        granted    = 1'b1;
                        cur_v      = 1'b1;
                        cur_aw     = 1'b0;
                        cur_own    = c;
                        cur_addr   = r_addr[c];
                        cur_len    = r_len[c];
                        beats_left = int'(r_len[c]) + 1;
                    end
                end
            end
        end else begin
            if (aw_hs) begin
                cur_aw = 1'b1;
                idq.push_back(cur_own);
                has_req[cur_own] = 1'b0;
            end
            if (w_hs) begin
                dcnt[cur_own]++;
                beats_left--;
                if (beats_left == 0) begin
                    cur_v = 1'b0;
                    rr    = (cur_own + 1) % NR;
                    pend_b++;
                end
            end
        end
        if (b_hs) begin
            void'(idq.pop_front());
            pend_b--;
            if (b_budget > 0) b_budget--;
        end
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        evaluate();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_aw_valid"}, bus.aw_valid, 0);
        check_eq({tag, "_aw_addr"}, bus.aw_addr, 0);
        check_eq({tag, "_aw_len"}, bus.aw_len, 0);
        check_eq({tag, "_w_valid"}, bus.w_valid, 0);
        check_eq({tag, "_w_data"}, bus.w_data, 0);
        check_eq({tag, "_w_last"}, bus.w_last, 0);
        check_eq({tag, "_wdata_ready"}, bus.wdata_ready, 0);
        check_eq({tag, "_req_ready"}, bus.req_ready, 0);
        check_eq({tag, "_b_ready"}, bus.b_ready, 0);
        check_eq({tag, "_done"}, bus.done, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        drive();
        @(negedge clk);
        check_zero(tag);
        evaluate();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input int awr, input int wr, input int bv, input int wv);
        p_awr = awr;
        p_wr  = wr;
        p_bv  = bv;
        p_wv  = wv;
    endtask

    initial begin
        int aw0, beats0, done0, guard;
        for (int i = 0; i < NR; i++) begin
            has_req[i] = 1'b0;
            r_addr[i]  = '0;
            r_len[i]   = '0;
            dcnt[i]    = 0;
            obs_done[i] = 0;
        end
        req_mask = '0;
        p_req = 0; len_max = 0; b_budget = -1; ce_rand = 1'b0;
        obs_aw = 0; obs_beats = 0; obs_simul = 0;
        set_ready(0, 0, 0, 0);
        model_reset();
        do_reset("rst");

        // single burst from requester 0
        set_ready(100, 100, 100, 100);
        has_req[0] = 1'b1; r_addr[0] = 32'h1000; r_len[0] = 4'd3;
        aw0 = obs_aw; beats0 = obs_beats; done0 = obs_done[0];
        repeat (15) cycle();
        check_eq("single_aw_count", obs_aw - aw0, 1);
        check_eq("single_beats", obs_beats - beats0, 4);
        check_eq("single_done0", obs_done[0] - done0, 1);

        // round-robin between two persistent requesters, single-beat bursts
        do_reset("rst_rr");
        grant_log.delete(); aw_cyc.delete();
        req_mask = 3'b011; p_req = 100; len_max = 0;
        repeat (16) cycle();
        for (int k = 0; k < 4; k++) check_eq("rr_order", (k < grant_log.size()) ? grant_log[k] : -1, k % 2);
        for (int k = 0; k < 3; k++)
            check_eq("rr_bubble_period", (k + 1 < aw_cyc.size()) ? aw_cyc[k+1] - aw_cyc[k] : -1, 3);

        // backpressure: AW stalled 5 cycles, then toggling W ready
        req_mask = '0; p_req = 0;
        repeat (20) cycle();
        has_req[2] = 1'b1; r_addr[2] = 32'h2000_0040; r_len[2] = 4'd5;
        beats0 = obs_beats; done0 = obs_done[2];
        set_ready(0, 50, 100, 100);
        repeat (6) cycle();
        check_eq("bp_aw_held", bus.aw_valid, 1);
        set_ready(100, 50, 100, 70);
        repeat (40) cycle();
        check_eq("bp_beats", obs_beats - beats0, 6);
        check_eq("bp_done2", obs_done[2] - done0, 1);

        // outstanding limit: no B until budget is released
        do_reset("rst_lim");
        req_mask = '1; p_req = 100; len_max = 1; b_budget = 0;
        set_ready(100, 100, 100, 100);
        aw0 = obs_aw;
        repeat (60) cycle();
        check_eq("limit_aw_count", obs_aw - aw0, MO);
        check_eq("limit_aw_valid", bus.aw_valid, 0);
        done0 = obs_done[0] + obs_done[1] + obs_done[2];
        b_budget = 1;
        repeat (20) cycle();
        check_eq("limit_ninth_aw", obs_aw - aw0, MO + 1);
        check_eq("limit_one_b", obs_done[0] + obs_done[1] + obs_done[2] - done0, 1);
        b_budget = -1;

        // long randomised run with clock-enable gaps
        ce_rand = 1'b1; len_max = 7;
        for (int blk = 0; blk < 15; blk++) begin
            set_ready(30 + $urandom_range(70), 30 + $urandom_range(70),
                      20 + $urandom_range(80), 40 + $urandom_range(60));
            p_req = 20 + $urandom_range(80);
            repeat (100) cycle();
        end
        check_eq("simul_aw_b_seen", obs_simul > 0, 1);

        // reset in the middle of a data phase
        ce_rand = 1'b0; len_max = 7;
        set_ready(100, 30, 50, 100);
        guard = 0;
        while (!(cur_v && cur_aw && beats_left > 1) && guard < 300) begin
            cycle();
            guard++;
        end
        check_eq("mid_data_reached", guard < 300, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive();
        @(negedge clk);
        check_zero("abort");
        evaluate();
        @(posedge clk);
        #1;
        set_ready(100, 100, 100, 100);
        repeat (100) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/m_axi_wr_burst_arbiter.md
Name: m_axi_wr_burst_arbiter

Overview:
Shares one AXI4 master write port between NUM_REQ burst requesters. Each requester sits behind its own m_axi data FIFO. The block grants requesters round-robin, issues AW for the granted burst, then streams that requester's W beats. It keeps an in-order ID queue so each B response is routed back to the requester that issued the burst. It sits between the per-kernel write FIFOs and the shared m_axi write channels.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 64, AXI address width
DATA_WIDTH, 512, AXI/W data width
LEN_WIDTH, 8, burst length field width (beats-1 encoding)
MAX_OUTSTANDING, 8, maximum bursts awaiting B response (power of two)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
clk_en  in  1  global clock enable; when 0, all state holds
req_valid  in  NUM_REQ  per-requester burst request
req_ready  out  NUM_REQ  one-cycle accept pulse on the granted requester's AW handshake
req_addr  in  NUM_REQ*ADDR_WIDTH  burst start address, flattened with requester i at slice i
req_len  in  NUM_REQ*LEN_WIDTH  beats-1
wdata_valid  in  NUM_REQ  requester data FIFO non-empty
wdata_ready  out  NUM_REQ  requester data FIFO read strobe
wdata  in  NUM_REQ*DATA_WIDTH  requester data
aw_valid  out  1  AXI AW valid
aw_ready  in  1  AXI AW ready
aw_addr  out  ADDR_WIDTH  AXI AW address
aw_len  out  LEN_WIDTH  AXI AW len
w_valid  out  1  AXI W valid
w_ready  in  1  AXI W ready
w_data  out  DATA_WIDTH  AXI W data
w_last  out  1  AXI W last
b_valid  in  1  AXI B valid
b_ready  out  1  AXI B ready
done  out  NUM_REQ  one-cycle pulse to the owning requester per B handshake

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, outstanding=0, ID queue empty. All valid/ready/pulse outputs are 0. aw_addr, aw_len, w_data and w_last are 0.
- Handshake: a transfer occurs when valid & ready & clk_en are all 1.
- IDLE:
  - Entry condition: outstanding < MAX_OUTSTANDING and some req_valid is set.
  - Grant goes to the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - On grant, register gnt, addr and len (beat_cnt := len), then go to ADDR.
  - Latency: req_valid to aw_valid is exactly 1 cycle.
- ADDR:
  - aw_valid=1 with the registered addr/len; these hold stable until aw_ready.
  - On the AW handshake: req_ready[gnt] pulses, gnt is pushed into the ID queue, outstanding increments, then go to DATA.
- DATA:
  - w_valid=wdata_valid[gnt]; w_data=wdata[gnt]; wdata_ready[gnt]=w_ready. All other wdata_ready bits are 0.
  - w_last=(beat_cnt==0). Each W handshake decrements beat_cnt.
  - On the last-beat handshake: rr_ptr=(gnt+1) mod NUM_REQ, then go to IDLE.
  - A new grant is not evaluated in that same cycle; there is one IDLE bubble.
- Burst ownership: a granted burst is never preempted. Other req_valid inputs are ignored until it returns to IDLE.
- B path:
  - b_ready=1 whenever the ID queue is non-empty.
  - On a B handshake: pop the queue head h, pulse done[h], decrement outstanding.
- Simultaneous AW and B handshakes in one cycle: outstanding unchanged; queue push and pop both occur.
- Full condition: when outstanding==MAX_OUTSTANDING, no new grant is issued, but the in-flight DATA phase completes.
- B with the queue empty cannot occur because b_ready=0. b_valid is ignored in that state.
- A reset mid-burst aborts immediately. All outputs go to their reset values next cycle, the queue is flushed, and partial bursts are not completed.

Optional Feature:
M_AXI_WR_ARB_BRESP_EN
- Defined: adds input b_resp[1:0] and output done_err[NUM_REQ]. done_err[h] pulses together with done[h] when b_resp is SLVERR or DECERR (b_resp[1]=1).
- Undefined: neither port exists, and B response codes are ignored.

Test Plan:
- Single request: NUM_REQ=2, req0 len=3, addr=0x1000, aw_ready=1, w_ready=1, data always valid. Expect aw_valid 1 cycle after req_valid, 4 W beats with w_last on the 4th, req_ready[0] pulse, done[0] on B.
- Round-robin: req0 and req1 both held valid, len=0. Expect grants in order 0,1,0,1 and one IDLE cycle between bursts.
- Backpressure: aw_ready low 5 cycles, then w_ready toggling. Expect aw_addr/aw_len stable, no lost or duplicated beats, wdata_ready only on the granted requester.
- Outstanding limit: MAX_OUTSTANDING=8, b_valid held 0. Expect exactly 8 AW handshakes then no aw_valid. One B then allows a 9th AW, and done routes to the correct requester in issue order.
- Simultaneous events: B handshake in the same cycle as an AW handshake. Expect outstanding unchanged. Reset asserted mid-DATA: all outputs 0 next cycle and the queue empty.
- With M_AXI_WR_ARB_BRESP_EN defined: b_resp=2'b10 on the second B. Expect done_err pulses for the matching requester only.
